spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- SPI master (mode 0, MSB first) that acts as the bank-side reader/writer for banco_registros_spi through its second port (addr2/wr2/data2/hold_ctrl).
- On start, it takes the bank read path (hold_ctrl), fetches words 1..n_tx, and shifts the low byte of each word out on MOSI.
- It captures one MISO byte per word and writes it back to the same bank address.
- It sits between the register bank and the external SPI pins.

Parameters:
- N, 32, bank depth in words; address width is $clog2(N).
- W, 32, bank word width.
- CLK_DIV, 4, clk_i cycles per SCLK half-period; must be >= 4.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  single-cycle burst request.
- n_tx_i  in  $clog2(N)  number of words to transfer; latched on an accepted start.
- busy_o  out  1  high from accepted start until DONE exits.
- done_o  out  1  one-cycle pulse at end of burst.
- hold_ctrl_o  out  1  selects the bank read address to addr2.
- addr_o  out  $clog2(N)  drives bank addr2 for both read and write.
- rdata_i  in  W  bank data_o.
- wr_o  out  1  bank wr2.
- wdata_o  out  W  bank data2 = {zeros, rx_byte}.
- sclk_o  out  1  SPI clock; idles low.
- mosi_o  out  1  SPI data out.
- miso_i  in  1  SPI data in; asynchronous.
- cs_n_o  out  1  chip select, active low.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - Outputs: cs_n_o=1, sclk_o=0, mosi_o=0, wr_o=0, hold_ctrl_o=0, busy_o=0, done_o=0, addr_o=0, wdata_o=0.
  - State returns to IDLE; idx, bit count, divider and shift registers clear.
- Start acceptance:
  - A start is accepted only in IDLE with n_tx_i != 0.
  - start_i while busy, or with n_tx_i == 0, is ignored: no CS activity, no done pulse.
  - n_tx_i > N-1 is clamped to N-1.
- State IDLE:
  - cs_n_o=1, hold_ctrl_o=0.
  - On an accepted start: latch n_tx, set idx=1, set busy_o=1, go to FETCH.
- State FETCH (1 cycle):
  - hold_ctrl_o=1, addr_o=idx, cs_n_o=0.
  - Bank read latency is 1 cycle: rdata_i is valid on the next edge.
- State LOAD (1 cycle):
  - tx_shift <= rdata_i[7:0]; mosi_o <= rdata_i[7]; go to SHIFT.
- State SHIFT (16*CLK_DIV cycles per byte):
  - The divider counts CLK_DIV cycles per half-period, and sclk_o toggles at each terminal count.
  - On each rising edge of sclk_o, shift the synchronized MISO into rx_shift.
  - On each falling edge of sclk_o, drive the next tx bit.
  - After the 8th falling edge (sclk_o back to 0), go to WRITEBACK.
- State WRITEBACK (1 cycle):
  - wr_o=1, addr_o=idx, wdata_o={(W-8) zeros, rx_byte}, hold_ctrl_o=1.
  - If idx == n_tx, go to DONE; otherwise idx++ and go to FETCH.
- State DONE (1 cycle):
  - done_o=1, cs_n_o=1, hold_ctrl_o=0, busy_o=0 on exit; return to IDLE.
- Chip select:
  - cs_n_o stays low continuously from FETCH of the first word until DONE; there is no deassertion between words.
  - Gap between bytes: 3 cycles (WRITEBACK, FETCH, LOAD) with SCLK low.
- MISO synchronization:
  - miso_i passes through a 2-flop synchronizer.
  - The sample is taken in the cycle sclk_o rises, which is valid because the slave changes data on the falling edge CLK_DIV >= 4 cycles earlier.
- wr_o is high only in WRITEBACK, never in the same cycle as FETCH.
- All outputs are registered.

Decomposition:
- Package spi_pkg:
  - typedef enum state_t {IDLE, FETCH, LOAD, SHIFT, WRITEBACK, DONE}.
  - localparam BYTE_W = 8.
  - localparam FIRST_DATA_ADDR = 1.
- Sub-module spi_clk_div:
  - Divider counter producing one-cycle rise_tick/fall_tick strobes and sclk.
  - Enabled only in SHIFT; holds sclk low when disabled.
- The top level contains the FSM, the index counter, the shift registers and the synchronizer.

Test Plan:
1. Reset: assert rst_i with no clock running → cs_n_o=1, sclk_o=0, wr_o=0, busy_o=0 immediately; hold 5 cycles, no activity.
2. Single-word loopback (miso tied to mosi), bank[1]=0x000000A5, start with n_tx_i=1:
   - MOSI sequence is 1,0,1,0,0,1,0,1.
   - 8 SCLK pulses of 8 cycles each.
   - Writeback: wr_o at addr 1 with wdata 0x000000A5.
   - done_o pulses once; busy_o falls.
3. Three-word burst, bank[1..3]=0x11,0x22,0x33, slave model returning 0x3C,0xC3,0x0F:
   - MOSI bytes are 11,22,33.
   - Writebacks (addr,data): (1,0x3C), (2,0xC3), (3,0x0F).
   - cs_n_o is low without glitch for the whole burst.
4. Ignored starts:
   - start_i pulsed mid-burst → burst length unchanged, single done_o.
   - start with n_tx_i=0 → cs_n_o stays 1, no done_o.
5. Asynchronous reset mid-SHIFT (bit 4 of the second word) → cs_n_o=1, sclk_o=0, busy_o=0 before the next clk edge; a following start with n_tx_i=1 completes normally.
6. Clamp: N=32, n_tx_i=31 (max value), bank[31]=0x5A, loopback → 31 writebacks, the last at addr 31 with data 0x5A; addr_o never reaches 0.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and constants for the SPI bank master
package spi_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, WRITEBACK, DONE} state_t;
  localparam int BYTE_W = 8;
  localparam int FIRST_DATA_ADDR = 1;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: SCLK generator with strobes on the cycle whose edge toggles sclk
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt;
  logic term;
  always_comb begin
    term = en_i && (cnt == CW'(CLK_DIV - 1));
    rise_tick_o = term && !sclk_o;
    fall_tick_o = term && sclk_o;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
      sclk_o <= 1'b0;
    end else if (!en_i) begin
      cnt <= '0;
      sclk_o <= 1'b0;
    end else begin
      cnt <= term ? '0 : cnt + 1'b1;
      sclk_o <= term ? ~sclk_o : sclk_o;
    end
  end
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: mode-0 SPI master streaming bank words 1..n_tx out and
// writing each received byte back to the same bank address
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 32,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [$clog2(N)-1:0] n_tx_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 hold_ctrl_o,
  output logic [$clog2(N)-1:0] addr_o,
  input  logic [W-1:0]         rdata_i,
  output logic                 wr_o,
  output logic [W-1:0]         wdata_o,
  output logic                 sclk_o,
  output logic                 mosi_o,
  input  logic                 miso_i,
  output logic                 cs_n_o
);
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] MAX_TX = AW'(N - 1);
  localparam logic [AW-1:0] FIRST = AW'(FIRST_DATA_ADDR);
  state_t state;
  logic [AW-1:0] idx, n_tx;
  logic [2:0] bit_cnt;
  logic [BYTE_W-1:0] tx_shift, rx_shift;
  logic [1:0] miso_q;
  logic rise_tick, fall_tick;
  logic unused_rdata;
  assign unused_rdata = ^rdata_i[W-1:BYTE_W];
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (state == SHIFT),
    .sclk_o     (sclk_o),
    .rise_tick_o(rise_tick),
    .fall_tick_o(fall_tick)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      n_tx <= '0;
      bit_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      miso_q <= '0;
      cs_n_o <= 1'b1;
      mosi_o <= 1'b0;
      wr_o <= 1'b0;
      hold_ctrl_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      addr_o <= '0;
      wdata_o <= '0;
    end else begin
      miso_q <= {miso_q[0], miso_i};
      wr_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        IDLE: if (start_i && n_tx_i != '0) begin
          n_tx <= (n_tx_i > MAX_TX) ? MAX_TX : n_tx_i;
          idx <= FIRST;
          addr_o <= FIRST;
          busy_o <= 1'b1;
          hold_ctrl_o <= 1'b1;
          cs_n_o <= 1'b0;
          state <= FETCH;
        end
        FETCH: state <= LOAD;
        LOAD: begin
          tx_shift <= rdata_i[BYTE_W-1:0];
          mosi_o <= rdata_i[BYTE_W-1];
          bit_cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          if (rise_tick) rx_shift <= {rx_shift[BYTE_W-2:0], miso_q[1]};
          // the byte is finished on the 8th falling edge, when sclk returns low
          if (fall_tick) begin
            tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
            mosi_o <= tx_shift[BYTE_W-2];
            bit_cnt <= bit_cnt + 1'b1;
            if (&bit_cnt) begin
              wr_o <= 1'b1;
              wdata_o <= {{(W-BYTE_W){1'b0}}, rx_shift};
              state <= WRITEBACK;
            end
          end
        end
        WRITEBACK: if (idx == n_tx) begin
          done_o <= 1'b1;
          cs_n_o <= 1'b1;
          hold_ctrl_o <= 1'b0;
          state <= DONE;
        end else begin
          idx <= idx + 1'b1;
          addr_o <= idx + 1'b1;
          state <= FETCH;
        end
        DONE: begin
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed+random bursts against a bank/slave model
module tb_spi_master_ctrl;
  localparam int N = 32, W = 32, CLK_DIV = 4, AW = 5;
  logic clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, clk_en = 1'b0;
  logic [AW-1:0] n_tx_i = '0;
  logic busy_o, done_o, hold_ctrl_o, wr_o, sclk_o, mosi_o, miso_i, cs_n_o;
  logic [AW-1:0] addr_o;
  logic [W-1:0] rdata_i, wdata_o;
  logic [W-1:0] mem [N];
  logic [7:0] resp [N];
  logic loop = 1'b0, sl_bit = 1'b0;
  int errors = 0, checks = 0;
  bit mosi_q[$];
  int wb_addr_q[$];
  logic [W-1:0] wb_data_q[$];
  int done_cnt = 0, cs_fall_cnt = 0, cs_rise_cnt = 0, rise_cnt = 0, bad_hi = 0, addr0_cnt = 0;
  int hi_len = 0, bitn = 0, byten = 0;
  logic sclk_prev = 1'b0, cs_prev = 1'b1;

  spi_master_ctrl #(.N(N), .W(W), .CLK_DIV(CLK_DIV)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .n_tx_i(n_tx_i),
    .busy_o(busy_o), .done_o(done_o), .hold_ctrl_o(hold_ctrl_o), .addr_o(addr_o),
    .rdata_i(rdata_i), .wr_o(wr_o), .wdata_o(wdata_o), .sclk_o(sclk_o),
    .mosi_o(mosi_o), .miso_i(miso_i), .cs_n_o(cs_n_o)
  );

  always #5 if (clk_en) clk_i = ~clk_i;
  always @(posedge clk_i) rdata_i <= mem[addr_o];
  assign miso_i = loop ? mosi_o : sl_bit;

  // bus monitor and mode-0 slave: presents the next response bit after each falling sclk
  always @(negedge clk_i) begin
    if (sclk_o && !sclk_prev) begin
      rise_cnt++;
      mosi_q.push_back(mosi_o);
      hi_len = 0;
    end
    if (sclk_o) hi_len++;
    if (!sclk_o && sclk_prev) begin
      if (hi_len != CLK_DIV) bad_hi++;
      bitn++;
      if (bitn == 8) begin
        bitn = 0;
        byten++;
      end
    end
    if (cs_n_o) begin
      bitn = 0;
      byten = 0;
    end
    sl_bit = resp[byten % N][7 - bitn];
    if (wr_o) begin
      wb_addr_q.push_back(int'(addr_o));
      wb_data_q.push_back(wdata_o);
    end
    if (done_o) done_cnt++;
    if (!cs_n_o && cs_prev) cs_fall_cnt++;
    if (cs_n_o && !cs_prev) cs_rise_cnt++;
    if (busy_o && addr_o == '0) addr0_cnt++;
    sclk_prev = sclk_o;
    cs_prev = cs_n_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic start_burst(input int n);
    start_i = 1'b1;
    n_tx_i = AW'(n);
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int bound);
    int c = 0;
    while (done_cnt == d0 && c < bound) begin
      tick(1);
      c++;
    end
    check($sformatf("%s done seen", tag), 32'(done_cnt != d0), 32'd1);
  endtask

  // reference: word i sends mem[i][7:0] MSB first and writes back the slave's byte i-1
  task automatic check_burst(input string tag, input int n, input int wb0, input int mq0);
    logic [7:0] exp_rx, got;
    check($sformatf("%s wb count", tag), 32'(wb_addr_q.size() - wb0), 32'(n));
    for (int i = 1; i <= n; i++) begin
      exp_rx = loop ? mem[i][7:0] : resp[i-1];
      if (wb0 + i - 1 < wb_addr_q.size()) begin
        check($sformatf("%s wb%0d addr", tag, i), 32'(wb_addr_q[wb0+i-1]), 32'(i));
        check($sformatf("%s wb%0d data", tag, i), wb_data_q[wb0+i-1], {24'h0, exp_rx});
      end
      if (mq0 + 8 * i <= mosi_q.size()) begin
        got = '0;
        for (int b = 0; b < 8; b++) got = {got[6:0], mosi_q[mq0 + 8*(i-1) + b]};
        check($sformatf("%s mosi byte%0d", tag, i), {24'h0, got}, {24'h0, mem[i][7:0]});
      end
    end
  endtask

  initial begin
    int wb0, mq0, d0, r0, bh0, cf0, cr0, a0, n, c;
    for (int i = 0; i < N; i++) begin
      mem[i] = $urandom;
      resp[i] = 8'($urandom);
    end
    #1 rst_i = 1'b1;
    #3;
    check("reset cs_n", 32'(cs_n_o), 32'd1);
    check("reset sclk", 32'(sclk_o), 32'd0);
    check("reset wr", 32'(wr_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset misc", {hold_ctrl_o, done_o, mosi_o, 24'(addr_o)}, 32'd0);
    check("reset wdata", wdata_o, 32'd0);
    clk_en = 1'b1;
    tick(5);
    check("reset hold cs_n", 32'(cs_n_o), 32'd1);
    check("reset hold activity", 32'(cs_fall_cnt + rise_cnt + wb_addr_q.size()), 32'd0);
    rst_i = 1'b0;
    tick(2);

    // single-word loopback
    loop = 1'b1;
    mem[1] = 32'h0000_00A5;
    wb0 = wb_addr_q.size(); mq0 = mosi_q.size(); d0 = done_cnt; r0 = rise_cnt; bh0 = bad_hi;
    start_burst(1);
    check("t2 busy", 32'(busy_o), 32'd1);
    wait_done("t2", d0, 200);
    tick(5);
    check_burst("t2", 1, wb0, mq0);
    check("t2 sclk pulses", 32'(rise_cnt - r0), 32'd8);
    check("t2 sclk high len", 32'(bad_hi - bh0), 32'd0);
    check("t2 done once", 32'(done_cnt - d0), 32'd1);
    check("t2 busy fall", 32'(busy_o), 32'd0);

    // three-word burst with scripted slave replies
    loop = 1'b0;
    mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33;
    resp[0] = 8'h3C; resp[1] = 8'hC3; resp[2] = 8'h0F;
    wb0 = wb_addr_q.size(); mq0 = mosi_q.size(); d0 = done_cnt; cf0 = cs_fall_cnt; cr0 = cs_rise_cnt;
    start_burst(3);
    wait_done("t3", d0, 400);
    tick(5);
    check_burst("t3", 3, wb0, mq0);
    check("t3 cs falls", 32'(cs_fall_cnt - cf0), 32'd1);
    check("t3 cs rises", 32'(cs_rise_cnt - cr0), 32'd1);

    // random burst, random data and replies
    n = $urandom_range(2, 6);
    for (int i = 1; i <= n; i++) begin
      mem[i] = $urandom;
      resp[i-1] = 8'($urandom);
    end
    wb0 = wb_addr_q.size(); mq0 = mosi_q.size(); d0 = done_cnt;
    start_burst(n);
    wait_done("rnd", d0, 100 * n + 50);
    tick(5);
    check_burst("rnd", n, wb0, mq0);
    check("rnd done once", 32'(done_cnt - d0), 32'd1);

    // start while busy is ignored
    loop = 1'b1;
    wb0 = wb_addr_q.size(); mq0 = mosi_q.size(); d0 = done_cnt;
    start_burst(2);
    tick(100);
    check("t4 busy mid", 32'(busy_o), 32'd1);
    start_burst(5);
    wait_done("t4", d0, 300);
    tick(20);
    check_burst("t4", 2, wb0, mq0);
    check("t4 done once", 32'(done_cnt - d0), 32'd1);

    // start with n_tx=0 is ignored
    d0 = done_cnt; cf0 = cs_fall_cnt;
    start_burst(0);
    tick(30);
    check("t4 zero cs", 32'(cs_fall_cnt - cf0), 32'd0);
    check("t4 zero done", 32'(done_cnt - d0), 32'd0);
    check("t4 zero busy", 32'(busy_o), 32'd0);

    // asynchronous reset during bit 4 of the second word
    loop = 1'b0;
    mq0 = mosi_q.size();
    start_burst(3);
    c = 0;
    while (mosi_q.size() < mq0 + 12 && c < 400) begin
      tick(1);
      c++;
    end
    check("t5 reached word2 bit4", 32'(mosi_q.size() >= mq0 + 12), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("t5 async cs_n", 32'(cs_n_o), 32'd1);
    check("t5 async sclk", 32'(sclk_o), 32'd0);
    check("t5 async busy", 32'(busy_o), 32'd0);
    tick(2);
    rst_i = 1'b0;
    tick(2);
    loop = 1'b1;
    mem[1] = {24'($urandom), 8'h96};
    wb0 = wb_addr_q.size(); mq0 = mosi_q.size(); d0 = done_cnt;
    start_burst(1);
    wait_done("t5 post", d0, 200);
    tick(5);
    check_burst("t5 post", 1, wb0, mq0);

    // full-depth burst
    for (int i = 1; i < N; i++) mem[i] = $urandom;
    mem[31] = {24'($urandom), 8'h5A};
    wb0 = wb_addr_q.size(); mq0 = mosi_q.size(); d0 = done_cnt; a0 = addr0_cnt;
    start_burst(31);
    wait_done("t6", d0, 31 * 80 + 100);
    tick(5);
    check_burst("t6", 31, wb0, mq0);
    if (wb_addr_q.size() > wb0) begin
      check("t6 last addr", 32'(wb_addr_q[wb_addr_q.size()-1]), 32'd31);
      check("t6 last data", wb_data_q[wb_data_q.size()-1], 32'h5A);
    end
    check("t6 addr never 0", 32'(addr0_cnt - a0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
